// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: size codes, FSM states and
// the byte-lane position helper used by the lane extract/merge logic.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] LANE_HALF_MASK = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Bit position of the least significant bit of the selected lane.
  // Big-endian puts byte offset 0 in bits 31:24, so the position is mirrored.
  function automatic logic [4:0] lane_lsb(input logic [1:0] offset,
                                          input logic [1:0] size,
                                          input logic       big_endian);
    logic [1:0] o;
    case (size)
      SZ_BYTE: o = offset;
      SZ_HALF: o = {offset[1], 1'b0};
      default: o = 2'b00;
    endcase
    if (!big_endian) begin
      lane_lsb = {o, 3'b000};
    end else begin
      case (size)
        SZ_BYTE: lane_lsb = {~o, 3'b000};
        SZ_HALF: lane_lsb = {~o[1], 4'b0000};
        default: lane_lsb = 5'd0;
      endcase
    end
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends load data from a sram word,
// and merges right-justified store data into a captured word.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  localparam logic BE = (BIG_ENDIAN != 0);

  logic [4:0]  lsb;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    lsb        = lane_lsb(offset, size, BE);
    shifted    = word >> lsb;
    load_data  = word;
    mask       = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
        mask      = LANE_BYTE_MASK << lsb;
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
        mask      = LANE_HALF_MASK << lsb;
      end
      default: begin
        load_data = word;
        mask      = 32'hFFFF_FFFF;
      end
    endcase
    merge_data = (word & ~mask) | ((wdata << lsb) & mask);
  end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Load/store sequencer between the MEM stage and a word-wide sram without byte
// enables. Define LSU_ALIGN_CHECK_EN to reject misaligned half/word requests.
module lsu_sram_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  lsu_state_t  state;
  logic [1:0]  offset_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic [31:0] wdata_q;

  logic [1:0]  req_size_n;
  logic        misaligned;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Size 11 is folded into word at the request boundary so nothing downstream sees it.
  assign req_size_n = (req_size == 2'b11) ? SZ_WORD : req_size;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((req_size_n == SZ_HALF) && req_addr[0]) ||
                      ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  lsu_byte_lane #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane (
    .word      (mem_dout),
    .wdata     (wdata_q),
    .offset    (offset_q),
    .size      (size_q),
    .is_signed (signed_q),
    .load_data (load_data),
    .merge_data(merge_data)
  );

  // Moore FSM; every output is loaded on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      offset_q   <= 2'b00;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      req_ready  <= 1'b1;
      stall      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_cs     <= 1'b0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            offset_q   <= req_addr[1:0];
            size_q     <= req_size_n;
            signed_q   <= req_signed;
            we_q       <= req_we;
            wdata_q    <= req_wdata;
            req_ready  <= 1'b0;
            stall      <= 1'b1;
            resp_rdata <= 32'h0;
            mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_we || (req_size_n != SZ_WORD)) begin
              state  <= READ;
              mem_cs <= 1'b1;
              mem_oe <= 1'b1;
            end else begin
              state   <= WRITE;
              mem_cs  <= 1'b1;
              mem_we  <= 1'b1;
              mem_din <= req_wdata;
            end
          end
        end
        READ: begin
          mem_oe <= 1'b0;
          if (!we_q) begin
            state      <= RESP;
            mem_cs     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end else begin
            state   <= WRITE;
            mem_we  <= 1'b1;
            mem_din <= merge_data;
          end
        end
        WRITE: begin
          state      <= RESP;
          mem_cs     <= 1'b0;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          stall      <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          stall      <= 1'b0;
          resp_valid <= 1'b0;
          mem_cs     <= 1'b0;
          mem_oe     <= 1'b0;
          mem_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_sram_ctrl.md
Name: lsu_sram_ctrl

Overview:
Load/store sequencer between the MEM pipeline stage and the word-wide sram model (cs/oe/we/addr/din/dout).
- Accepts one byte, halfword or word request at a time.
- Issues word-aligned sram accesses.
- Performs read-modify-write for sub-word stores, because the sram has no byte enables.
- Returns sign- or zero-extended load data.
- Asserts stall to the pipeline while busy.

Parameters:
ADDR_W, 32, request/sram address width.
BIG_ENDIAN, 1, 1: byte offset 0 maps to bits 31:24 (MIPS); 0: byte offset 0 maps to bits 7:0.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
req_valid  in  1  MEM stage presents a request.
req_ready  out  1  high only in IDLE; request is accepted when req_valid && req_ready.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
req_signed  in  1  loads only: sign-extend when 1.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-justified for sub-word.
resp_valid  out  1  one-cycle pulse; request is complete.
resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores.
resp_err  out  1  misaligned request, valid with resp_valid.
stall  out  1  high whenever state != IDLE.
mem_cs  out  1  sram chip select.
mem_oe  out  1  sram output enable.
mem_we  out  1  sram write enable.
mem_addr  out  ADDR_W  req_addr with bits [1:0] forced to 0.
mem_din  out  32  write word.
mem_dout  in  32  sram read word.

Behaviour:
- Reset: state IDLE. req_ready=1. All of the following are 0: stall, resp_valid, resp_rdata, resp_err, mem_cs, mem_oe, mem_we, mem_addr, mem_din.
- The FSM is Moore. All sram controls come from registered state/registers, so they are glitch-free.
- On acceptance, addr, size, signed, we and wdata are latched. Later changes to req_* have no effect until the next IDLE.
- States and transitions:
  - IDLE: on accept, a misaligned request goes to RESP. Otherwise a load or sub-word store goes to READ, and a word store goes to WRITE.
  - READ: mem_cs=1, mem_oe=1, mem_we=0. mem_dout is captured at the end of this cycle. A load then goes to RESP; a store goes to WRITE.
  - WRITE: mem_cs=1, mem_we=1, mem_oe=0, for exactly one cycle. mem_din is either the merged word (captured word with the selected lane replaced) or the full wdata for a word store. Then goes to RESP.
  - RESP: resp_valid=1 for one cycle, mem_cs=0. Goes to IDLE; the next request can be accepted in the following cycle.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - misaligned: 1 cycle
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Result: resp_err=1, no sram access, memory unchanged.
- Byte lane is addr[1:0]; half lane is addr[1]; lane mapping follows BIG_ENDIAN.
- Loads:
  - byte/half are sign-extended when req_signed=1, zero-extended otherwise;
  - word ignores req_signed.
- mem_addr and mem_din hold steady from the READ cycle through the WRITE cycle; they are not required to change in RESP.
- Reset mid-operation returns to IDLE at that edge.
  - Reset during READ: no memory side effect.
  - Reset during WRITE: the write may have committed; this is an accepted outcome.
  - A pending resp_valid is never produced.
- req_valid while busy is ignored (req_ready=0). It is not queued.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined: misalignment is detected as specified above.
- Undefined: no alignment check and resp_err is tied to 0.
  - Half uses addr[1].
  - Word ignores addr[1:0].
  - Access proceeds with normal latency.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum IDLE/READ/WRITE/RESP;
  - lane-select helper constants.
- One sub-module, lsu_byte_lane: combinational, implementing extract+extend for loads and merge for stores given lane, size and BIG_ENDIAN.

Test Plan:
1. Word load: sram[0x100]=0xDEADBEEF, load word 0x100. Expect:
   - READ asserts cs=1, oe=1;
   - resp_valid 2 cycles after accept;
   - rdata=0xDEADBEEF;
   - stall high 2 cycles.
2. Signed byte load, BIG_ENDIAN=1, sram[0x100]=0x12F45678, load byte 0x101. Expect rdata=0xFFFFFFF4 with signed=1 and 0x000000F4 with signed=0.
3. Half store RMW: sram[0x104]=0xAABBCCDD, store half 0x106 with wdata=0x00001234. Expect:
   - READ then WRITE;
   - mem_din=0xAABB1234;
   - we high exactly 1 cycle;
   - resp at 3 cycles.
4. Word store 0x108=0xCAFEF00D. Expect no READ cycle, WRITE din=0xCAFEF00D, resp at 2 cycles.
5. Misaligned word load 0x10A with LSU_ALIGN_CHECK_EN defined. Expect resp_err=1 at 1 cycle, cs never asserted. With the macro undefined, expect the word at 0x108 and err=0.
6. Reset asserted during the READ of a byte store, with req_valid held high. Expect:
   - IDLE next cycle;
   - no we pulse;
   - no resp_valid;
   - sram word unchanged;
   - the request is accepted again after rst_n releases.
